// File: rtl/bp_mem_io_arb_pkg.sv
// Shared types for the BlackParrot mem/io command arbiter.
package bp_mem_io_arb_pkg;

   localparam int unsigned ARB_N     = 2;
   localparam int unsigned IO_IDX    = 0;
   localparam int unsigned MEM_IDX   = 1;

   typedef enum logic [1:0] {e_idle, e_cmd, e_wait, e_resp} bp_arb_state_e;
   typedef enum logic {e_src_io = 1'b0, e_src_mem = 1'b1} bp_arb_src_e;

endpackage

// File: rtl/bp_rr_arb2.sv
// Two-input round-robin grant; a tie goes to the input not granted last time.
module bp_rr_arb2
   import bp_mem_io_arb_pkg::*;
(
   input  logic             clk_i,
   input  logic             reset_n_i,
   input  logic [ARB_N-1:0] req_i,
   input  logic             update_i,
   output logic [ARB_N-1:0] grant_o,
   output bp_arb_src_e      winner_o
);

   bp_arb_src_e last_q;

   always_comb begin
      grant_o          = '0;
      grant_o[MEM_IDX] = req_i[MEM_IDX] & (~req_i[IO_IDX] | (last_q == e_src_io));
      grant_o[IO_IDX]  = req_i[IO_IDX] & (~req_i[MEM_IDX] | (last_q == e_src_mem));
      winner_o         = grant_o[MEM_IDX] ? e_src_mem : e_src_io;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         last_q <= e_src_io;
      end else if (update_i) begin
         last_q <= winner_o;
      end
   end

endmodule

// File: rtl/bp_mem_io_arbiter.sv
// Merges the mem and io command channels into one single-outstanding stream.
// Optional response watchdog: define BP_MEM_IO_ARB_TIMEOUT_EN.
module bp_mem_io_arbiter
   import bp_mem_io_arb_pkg::*;
#(
   parameter int unsigned msg_width_p = 0,
   parameter int unsigned timeout_p   = 1024
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
   output logic                   timeout_o,
`endif
   input  logic [msg_width_p-1:0] mem_cmd_i,
   input  logic                   mem_cmd_v_i,
   output logic                   mem_cmd_ready_o,
   output logic [msg_width_p-1:0] mem_resp_o,
   output logic                   mem_resp_v_o,
   input  logic                   mem_resp_yumi_i,
   input  logic [msg_width_p-1:0] io_cmd_i,
   input  logic                   io_cmd_v_i,
   output logic                   io_cmd_ready_o,
   output logic [msg_width_p-1:0] io_resp_o,
   output logic                   io_resp_v_o,
   input  logic                   io_resp_yumi_i,
   output logic [msg_width_p-1:0] fwd_cmd_o,
   output logic                   fwd_cmd_v_o,
   input  logic                   fwd_cmd_ready_i,
   input  logic [msg_width_p-1:0] fwd_resp_i,
   input  logic                   fwd_resp_v_i,
   output logic                   fwd_resp_yumi_o
);

   bp_arb_state_e          state_q;
   bp_arb_src_e            src_q;
   logic [msg_width_p-1:0] cmd_q;
   logic [msg_width_p-1:0] resp_q;

   logic [ARB_N-1:0] req;
   logic [ARB_N-1:0] grant;
   bp_arb_src_e      winner;
   logic             is_idle;
   logic             xfer;
   logic             resp_yumi;

   always_comb begin
      req          = '0;
      req[MEM_IDX] = mem_cmd_v_i;
      req[IO_IDX]  = io_cmd_v_i;
   end

   bp_rr_arb2 u_rr_arb2 (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .req_i     (req),
      .update_i  (xfer),
      .grant_o   (grant),
      .winner_o  (winner)
   );

   // Readies and yumi are gated by reset so they drop the moment reset asserts.
   assign is_idle         = (state_q == e_idle);
   assign mem_cmd_ready_o = reset_n_i & is_idle & grant[MEM_IDX];
   assign io_cmd_ready_o  = reset_n_i & is_idle & grant[IO_IDX];
   assign xfer            = mem_cmd_ready_o | io_cmd_ready_o;
   assign fwd_resp_yumi_o = reset_n_i & fwd_resp_v_i & (is_idle | (state_q == e_wait));

   assign fwd_cmd_o    = cmd_q;
   assign fwd_cmd_v_o  = (state_q == e_cmd);
   assign mem_resp_o   = resp_q;
   assign io_resp_o    = resp_q;
   assign mem_resp_v_o = (state_q == e_resp) & (src_q == e_src_mem);
   assign io_resp_v_o  = (state_q == e_resp) & (src_q == e_src_io);
   assign resp_yumi    = (src_q == e_src_mem) ? mem_resp_yumi_i : io_resp_yumi_i;

`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(timeout_p + 1);
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_q;
   assign timeout_o = timeout_q;
`endif

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= e_idle;
         src_q     <= e_src_io;
         cmd_q     <= '0;
         resp_q    <= '0;
`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            e_idle: begin
               if (xfer) begin
                  cmd_q   <= (winner == e_src_mem) ? mem_cmd_i : io_cmd_i;
                  src_q   <= winner;
                  state_q <= e_cmd;
               end
            end
            e_cmd: begin
               if (fwd_cmd_ready_i) begin
                  state_q <= e_wait;
`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end
            end
            e_wait: begin
               if (fwd_resp_v_i) begin
                  resp_q  <= fwd_resp_i;
                  state_q <= e_resp;
               end
`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
               // Watchdog expiry echoes the command header back as the response.
               else if (cnt_q == CNT_W'(timeout_p - 1)) begin
                  resp_q    <= cmd_q;
                  timeout_q <= 1'b1;
                  state_q   <= e_resp;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
`endif
            end
            e_resp: begin
               if (resp_yumi) begin
                  state_q <= e_idle;
               end
            end
            default: state_q <= e_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_bp_mem_io_arbiter.sv
// Directed self-checking bench for bp_mem_io_arbiter (16-bit messages).
module tb_bp_mem_io_arbiter;

   localparam int unsigned W = 16;

   logic         clk;
   logic         reset_n;
   logic [W-1:0] mem_cmd, io_cmd, fwd_resp;
   logic         mem_cmd_v, io_cmd_v, fwd_cmd_ready, fwd_resp_v;
   logic         mem_resp_yumi, io_resp_yumi;
   logic [W-1:0] mem_resp, io_resp, fwd_cmd;
   logic         mem_cmd_ready, io_cmd_ready, mem_resp_v, io_resp_v;
   logic         fwd_cmd_v, fwd_resp_yumi;
`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
   logic         timeout;
`endif

   int n_assert = 0;
   int n_fail   = 0;

   bp_mem_io_arbiter #(.msg_width_p(W), .timeout_p(8)) dut (
      .clk_i           (clk),
      .reset_n_i       (reset_n),
`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
      .timeout_o       (timeout),
`endif
      .mem_cmd_i       (mem_cmd),
      .mem_cmd_v_i     (mem_cmd_v),
      .mem_cmd_ready_o (mem_cmd_ready),
      .mem_resp_o      (mem_resp),
      .mem_resp_v_o    (mem_resp_v),
      .mem_resp_yumi_i (mem_resp_yumi),
      .io_cmd_i        (io_cmd),
      .io_cmd_v_i      (io_cmd_v),
      .io_cmd_ready_o  (io_cmd_ready),
      .io_resp_o       (io_resp),
      .io_resp_v_o     (io_resp_v),
      .io_resp_yumi_i  (io_resp_yumi),
      .fwd_cmd_o       (fwd_cmd),
      .fwd_cmd_v_o     (fwd_cmd_v),
      .fwd_cmd_ready_i (fwd_cmd_ready),
      .fwd_resp_i      (fwd_resp),
      .fwd_resp_v_i    (fwd_resp_v),
      .fwd_resp_yumi_o (fwd_resp_yumi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      #0;
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks both upstream valids and readies at once: {mem_resp_v, io_resp_v, mem_rdy, io_rdy}.
   task automatic chk_up(input string tag, input logic [3:0] exp);
      #1;
      chk(tag, {28'd0, mem_resp_v, io_resp_v, mem_cmd_ready, io_cmd_ready}, {28'd0, exp});
   endtask

   initial begin
      logic [W-1:0] exp_cmd;
      logic         exp_mem;

      reset_n = 1'b0; mem_cmd = '0; io_cmd = '0; fwd_resp = '0;
      mem_cmd_v = 1'b1; io_cmd_v = 1'b1; fwd_cmd_ready = 1'b0; fwd_resp_v = 1'b0;
      mem_resp_yumi = 1'b0; io_resp_yumi = 1'b0;

      // Reset state, with both command valids high.
      #12;
      chk_up("reset_up", 4'b0000);
      chk("reset_fwd_v", 32'(fwd_cmd_v), 32'd0);
      chk("reset_yumi", 32'(fwd_resp_yumi), 32'd0);
      chk("reset_fwd_cmd", 32'(fwd_cmd), 32'd0);
      chk("reset_resp", 32'(mem_resp), 32'd0);
      mem_cmd_v = 1'b0; io_cmd_v = 1'b0;
      reset_n = 1'b1;
      step();

      // Single mem command.
      mem_cmd = 16'h00A5; mem_cmd_v = 1'b1; fwd_cmd_ready = 1'b1;
      chk_up("t1_accept", 4'b0010);
      step();
      mem_cmd_v = 1'b0;
      chk("t1_fwd_v", 32'(fwd_cmd_v), 32'd1);
      chk("t1_fwd_cmd", 32'(fwd_cmd), 32'h00A5);
      chk_up("t1_cmd_up", 4'b0000);
      step();
      fwd_resp = 16'h5A01; fwd_resp_v = 1'b1;
      #1 chk("t1_yumi", 32'(fwd_resp_yumi), 32'd1);
      step();
      fwd_resp_v = 1'b0; io_resp_yumi = 1'b1;
      chk_up("t1_resp_up", 4'b1000);
      chk("t1_resp", 32'(mem_resp), 32'h5A01);
      step();
      io_resp_yumi = 1'b0;
      chk_up("t1_other_yumi_ignored", 4'b1000);
      mem_resp_yumi = 1'b1;
      step();
      mem_resp_yumi = 1'b0;
      chk_up("t1_back_idle", 4'b0000);

      // Fresh reset, then both channels held valid: mem, io, mem, io.
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      step();
      mem_cmd = 16'h1111; io_cmd = 16'h2222; mem_cmd_v = 1'b1; io_cmd_v = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_mem = (i % 2 == 0);
         exp_cmd = exp_mem ? 16'h1111 : 16'h2222;
         chk_up($sformatf("t2_grant%0d", i), {2'b00, exp_mem, ~exp_mem});
         step();
         chk($sformatf("t2_fwd%0d", i), 32'(fwd_cmd), 32'(exp_cmd));
         step();
         fwd_resp = 16'hC000 + 16'(i); fwd_resp_v = 1'b1;
         step();
         fwd_resp_v = 1'b0;
         chk_up($sformatf("t2_route%0d", i), {exp_mem, ~exp_mem, 2'b00});
         chk($sformatf("t2_data%0d", i), 32'(io_resp), 32'hC000 + 32'(i));
         mem_resp_yumi = exp_mem; io_resp_yumi = ~exp_mem;
         step();
         mem_resp_yumi = 1'b0; io_resp_yumi = 1'b0;
      end
      mem_cmd_v = 1'b0; io_cmd_v = 1'b0;

      // Backpressure on the forward command for 5 cycles.
      io_cmd = 16'h3C3C; io_cmd_v = 1'b1; fwd_cmd_ready = 1'b0;
      step();
      io_cmd_v = 1'b0; mem_cmd = 16'h4444; mem_cmd_v = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_hold%0d", i), {15'd0, fwd_cmd_v, fwd_cmd}, {15'd0, 1'b1, 16'h3C3C});
         chk_up($sformatf("t3_up%0d", i), 4'b0000);
         step();
      end
      fwd_cmd_ready = 1'b1;
      chk("t3_v_cycle6", 32'(fwd_cmd_v), 32'd1);
      step();
      chk("t3_done", 32'(fwd_cmd_v), 32'd0);

      // io response stalled for 4 cycles while mem keeps requesting.
      fwd_resp = 16'hBEEF; fwd_resp_v = 1'b1;
      step();
      fwd_resp_v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk_up($sformatf("t4_stall%0d", i), 4'b0100);
         step();
      end
      chk("t4_io_resp", 32'(io_resp), 32'hBEEF);
      io_resp_yumi = 1'b1;
      chk_up("t4_yumi_cycle", 4'b0100);
      step();
      io_resp_yumi = 1'b0;
      chk_up("t4_mem_ready", 4'b0010);
      step();
      mem_cmd_v = 1'b0;
      chk("t4_mem_fwd", 32'(fwd_cmd), 32'h4444);
      step();

      // Reset in WAIT, then a stray response is swallowed in IDLE.
      fwd_cmd_ready = 1'b0; mem_cmd_v = 1'b1;
      #2 reset_n = 1'b0;
      chk_up("t5_rst_up", 4'b0000);
      chk("t5_rst_fwd_v", 32'(fwd_cmd_v), 32'd0);
      mem_cmd_v = 1'b0;
      #2 reset_n = 1'b1;
      step();
      fwd_resp = 16'h7777; fwd_resp_v = 1'b1;
      #1 chk("t5_stray_yumi", 32'(fwd_resp_yumi), 32'd1);
      step();
      fwd_resp_v = 1'b0;
      chk_up("t5_no_resp", 4'b0000);
      step();
      chk_up("t5_no_resp2", 4'b0000);
      chk("t5_resp_clear", 32'(mem_resp), 32'd0);

`ifdef BP_MEM_IO_ARB_TIMEOUT_EN
      // Watchdog: no response, echoed command after 8 WAIT cycles.
      io_cmd = 16'h9A9A; io_cmd_v = 1'b1; fwd_cmd_ready = 1'b1;
      step();
      io_cmd_v = 1'b0;
      step();
      for (int i = 0; i < 7; i++) step();
      chk_up("t6_before", 4'b0000);
      chk("t6_to_before", 32'(timeout), 32'd0);
      step();
      chk_up("t6_expire", 4'b0100);
      chk("t6_echo", 32'(io_resp), 32'h9A9A);
      chk("t6_to", 32'(timeout), 32'd1);
      io_resp_yumi = 1'b1;
      step();
      io_resp_yumi = 1'b0;
      step();
      chk("t6_sticky", 32'(timeout), 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
